// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port SRAM: round-robin grant, burst lock, tagged read return.
// Define ARB_FIXED_PRIO_EN to make m0 win every contention (lock is still honoured).
module mem_port_arbiter #(
    parameter int unsigned ADDR_BW = 32,
    parameter int unsigned DATA_BW = 32,
    parameter int unsigned STRB_BW = DATA_BW / 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [ADDR_BW-1:0] m0_addr,
    input  logic [DATA_BW-1:0] m0_wdata,
    input  logic [STRB_BW-1:0] m0_strb,
    input  logic               m0_lock,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [DATA_BW-1:0] m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [ADDR_BW-1:0] m1_addr,
    input  logic [DATA_BW-1:0] m1_wdata,
    input  logic [STRB_BW-1:0] m1_strb,
    input  logic               m1_lock,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [DATA_BW-1:0] m1_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_BW-1:0] mem_addr,
    output logic [DATA_BW-1:0] mem_wdata,
    output logic [STRB_BW-1:0] mem_strb,
    input  logic [DATA_BW-1:0] mem_rdata,
    output logic               o_busy
);

    logic              gnt0_c;
    logic              gnt1_c;
    logic              lock_q;
    logic              lock_d;
    logic              owner_q;
    logic              owner_d;
`ifndef ARB_FIXED_PRIO_EN
    logic              last_q;
    logic              last_d;
`endif
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] id_q;
    logic [RD_LAT-1:0] id_d;
    logic              rd_push;
    logic              out_vld;
    logic              out_id;

    // Grant selection; requests are ignored while reset is asserted
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!ARESET) begin
            if (lock_q) begin
                if (owner_q) gnt1_c = m1_req;
                else         gnt0_c = m0_req;
            end else if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
                gnt0_c = 1'b1;
`else
                gnt0_c = last_q;
                gnt1_c = ~last_q;
`endif
            end else begin
                gnt0_c = m0_req;
                gnt1_c = m1_req;
            end
        end
    end

    assign m0_gnt = gnt0_c;
    assign m1_gnt = gnt1_c;

    // SRAM request mux, zero when idle
    always_comb begin
        mem_en    = gnt0_c | gnt1_c;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;
        if (gnt0_c) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_strb  = m0_strb;
        end else if (gnt1_c) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_strb  = m1_strb;
        end
    end

    assign rd_push = mem_en & ~mem_we;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        if (mem_en) begin
            lock_d  = gnt1_c ? m1_lock : m0_lock;
            owner_d = gnt1_c;
`ifndef ARB_FIXED_PRIO_EN
            last_d  = gnt1_c;
`endif
        end
        // Tag pipe: bit 0 is the newest read, bit RD_LAT-1 lines up with mem_rdata
        vld_d = RD_LAT'({vld_q, rd_push});
        id_d  = RD_LAT'({id_q, gnt1_c});
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
            vld_q   <= '0;
            id_q    <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end

    assign out_vld   = vld_q[RD_LAT-1];
    assign out_id    = id_q[RD_LAT-1];
    assign m0_rvalid = out_vld & ~out_id;
    assign m1_rvalid = out_vld & out_id;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
    assign o_busy    = (|vld_q) | lock_q;

endmodule
